packet_reverse_buffer: RTL and testbench

PACKET_REVERSE_BUFFER -- requirements
Module: packet_reverse_buffer

---
 rtl/packet_reverse_buffer.sv | 180 ++++++++++++++++++
 tb/tb_packet_reverse_buffer.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_reverse_buffer.sv
// Packet reverse buffer: captures up to DEPTH words of a packet, waits DELAY cycles,
// then replays the stored words last-to-first, optionally bit-reversing each word.
module packet_reverse_buffer #(
    parameter int DATA_W  = 4,
    parameter int DEPTH   = 4,
    parameter int BIT_REV = 1,
    parameter int DELAY   = 3
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_W-1:0]            in_data,
    input  logic                         in_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_W-1:0]            out_data,
    output logic                         out_last,
    output logic [$clog2(DEPTH+1)-1:0]   pkt_len,
    output logic                         overflow,
    output logic                         busy
);

    localparam int LEN_W = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int DLY_W = (DELAY > 0) ? $clog2(DELAY + 1) : 1;
    localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);
    localparam logic [DLY_W-1:0] DELAY_L = DLY_W'(DELAY);

    typedef enum logic [1:0] {
        FILL,
        HOLD,
        DRAIN
    } state_t;

    state_t              state, state_n;
    logic [LEN_W-1:0]    count, count_n;
    logic [DLY_W-1:0]    delay_cnt, delay_n;
    logic [IDX_W-1:0]    rd_idx, rd_idx_n;
    logic [LEN_W-1:0]    last_idx;
    logic                in_ready_n;
    logic                out_valid_n;
    logic                out_last_n;
    logic                overflow_n;
    logic                busy_n;
    logic [DATA_W-1:0]   out_data_n;
    logic [LEN_W-1:0]    pkt_len_n;
    logic                wr_en;
    logic [IDX_W-1:0]    wr_idx;
    logic [DATA_W-1:0]   mem [DEPTH];

    function automatic logic [DATA_W-1:0] present(input logic [DATA_W-1:0] word);
        logic [DATA_W-1:0] result;
        result = word;
        if (BIT_REV != 0) begin
            for (int i = 0; i < DATA_W; i++) begin
                result[i] = word[DATA_W-1-i];
            end
        end
        return result;
    endfunction

    always_comb begin
        state_n     = state;
        count_n     = count;
        delay_n     = delay_cnt;
        rd_idx_n    = rd_idx;
        in_ready_n  = in_ready;
        out_valid_n = out_valid;
        out_data_n  = out_data;
        out_last_n  = out_last;
        pkt_len_n   = pkt_len;
        overflow_n  = overflow;
        busy_n      = busy;
        wr_en       = 1'b0;
        wr_idx      = count[IDX_W-1:0];
        last_idx    = pkt_len - LEN_W'(1);

        case (state)
            FILL: begin
                in_ready_n  = 1'b1;
                out_valid_n = 1'b0;
                out_last_n  = 1'b0;
                busy_n      = 1'b0;
                if (in_valid && in_ready) begin
                    // The first word of a packet always fits, so it always clears the sticky flag
                    if (count == '0) begin
                        overflow_n = 1'b0;
                    end
                    if (count < DEPTH_L) begin
                        wr_en   = 1'b1;
                        count_n = count + LEN_W'(1);
                    end else begin
                        overflow_n = 1'b1;
                    end
                    if (in_last) begin
                        pkt_len_n  = count_n;
                        delay_n    = DELAY_L;
                        state_n    = HOLD;
                        in_ready_n = 1'b0;
                        busy_n     = 1'b1;
                    end
                end
            end

            HOLD: begin
                in_ready_n = 1'b0;
                busy_n     = 1'b1;
                if (delay_cnt == '0) begin
                    state_n     = DRAIN;
                    rd_idx_n    = last_idx[IDX_W-1:0];
                    out_valid_n = 1'b1;
                    out_data_n  = present(mem[rd_idx_n]);
                    out_last_n  = (last_idx == '0);
                end else begin
                    delay_n = delay_cnt - DLY_W'(1);
                end
            end

            DRAIN: begin
                in_ready_n = 1'b0;
                busy_n     = 1'b1;
                if (out_valid && out_ready) begin
                    if (out_last) begin
                        state_n     = FILL;
                        count_n     = '0;
                        in_ready_n  = 1'b1;
                        out_valid_n = 1'b0;
                        out_last_n  = 1'b0;
                        busy_n      = 1'b0;
                    end else begin
                        rd_idx_n   = rd_idx - IDX_W'(1);
                        out_data_n = present(mem[rd_idx_n]);
                        out_last_n = (rd_idx_n == '0);
                    end
                end
            end

            default: begin
                state_n = FILL;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= FILL;
            count     <= '0;
            delay_cnt <= '0;
            rd_idx    <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            pkt_len   <= '0;
            overflow  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            count     <= count_n;
            delay_cnt <= delay_n;
            rd_idx    <= rd_idx_n;
            in_ready  <= in_ready_n;
            out_valid <= out_valid_n;
            out_data  <= out_data_n;
            out_last  <= out_last_n;
            pkt_len   <= pkt_len_n;
            overflow  <= overflow_n;
            busy      <= busy_n;
        end
    end

    // Storage carries no reset; stale words are never read because count restarts at zero
    always_ff @(posedge clock) begin
        if (wr_en && !reset) begin
            mem[wr_idx] <= in_data;
        end
    end

endmodule

// File: tb/tb_packet_reverse_buffer.sv
// Bench for packet_reverse_buffer: queue-based packet model checked every cycle,
// directed packets with literal expectations, randomized traffic, and a BIT_REV=0/DELAY=0 build.
module tb_packet_reverse_buffer;

    localparam int DEPTH = 4;
    localparam int DELAY = 3;

    logic       clock = 1'b0;
    logic       reset;
    logic       in_valid, in_ready, in_last;
    logic [3:0] in_data;
    logic       out_valid, out_ready, out_last;
    logic [3:0] out_data;
    logic [2:0] pkt_len;
    logic       overflow, busy;

    logic       b_in_valid, b_in_ready, b_in_last;
    logic [3:0] b_in_data;
    logic       b_out_valid, b_out_ready, b_out_last;
    logic [3:0] b_out_data;
    logic [2:0] b_pkt_len;
    logic       b_overflow, b_busy;

    int checks = 0;
    int errors = 0;
    bit rand_ready_en = 1'b0;
    logic [3:0] got[$];

    packet_reverse_buffer #(.DATA_W(4), .DEPTH(DEPTH), .BIT_REV(1), .DELAY(DELAY)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .pkt_len(pkt_len), .overflow(overflow), .busy(busy)
    );

    packet_reverse_buffer #(.DATA_W(4), .DEPTH(4), .BIT_REV(0), .DELAY(0)) dut_b (
        .clock(clock), .reset(reset),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_last(b_in_last),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_last(b_out_last),
        .pkt_len(b_pkt_len), .overflow(b_overflow), .busy(b_busy)
    );

    always #5 clock = ~clock;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: packet held as a queue, replay order precomputed at in_last
    typedef enum {M_FILL, M_HOLD, M_DRAIN} mphase_t;
    mphase_t    ph = M_FILL;
    logic [3:0] pkt[$];
    logic [3:0] outq[$];
    int         hold_left = 0;
    bit         model_on = 1'b0;
    logic       exp_in_ready = 1'b0, exp_out_valid = 1'b0, exp_out_last = 1'b0;
    logic       exp_overflow = 1'b0, exp_busy = 1'b0, exp_rst_vals = 1'b0;
    logic [3:0] exp_out_data = 4'h0;
    int         exp_pkt_len = 0;

    function automatic logic [3:0] mirror(input logic [3:0] w);
        logic [3:0] r;
        r = {<<{w}};
        return r;
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            model_on = 1'b1;
            ph = M_FILL;
            pkt.delete();
            outq.delete();
            exp_in_ready = 1'b0; exp_out_valid = 1'b0; exp_out_last = 1'b0;
            exp_overflow = 1'b0; exp_busy = 1'b0; exp_rst_vals = 1'b1;
            exp_out_data = 4'h0; exp_pkt_len = 0;
        end else begin
            exp_rst_vals = 1'b0;
            case (ph)
                M_FILL: begin
                    if (in_valid && exp_in_ready) begin
                        if (pkt.size() == 0) exp_overflow = 1'b0;
                        if (pkt.size() < DEPTH) pkt.push_back(in_data);
                        else exp_overflow = 1'b1;
                        if (in_last) begin
                            exp_pkt_len = pkt.size();
                            for (int i = pkt.size() - 1; i >= 0; i--) outq.push_back(mirror(pkt[i]));
                            pkt.delete();
                            hold_left = DELAY;
                            ph = M_HOLD;
                            exp_busy = 1'b1;
                            exp_in_ready = 1'b0;
                        end else begin
                            exp_in_ready = 1'b1;
                        end
                    end else begin
                        exp_in_ready = 1'b1;
                    end
                end
                M_HOLD: begin
                    if (hold_left == 0) begin
                        ph = M_DRAIN;
                        exp_out_valid = 1'b1;
                        exp_out_data = outq[0];
                        exp_out_last = (outq.size() == 1);
                    end else begin
                        hold_left--;
                    end
                end
                M_DRAIN: begin
                    if (out_ready) begin
                        void'(outq.pop_front());
                        if (outq.size() == 0) begin
                            ph = M_FILL;
                            exp_out_valid = 1'b0; exp_out_last = 1'b0;
                            exp_busy = 1'b0; exp_in_ready = 1'b1;
                        end else begin
                            exp_out_data = outq[0];
                            exp_out_last = (outq.size() == 1);
                        end
                    end
                end
                default: ph = M_FILL;
            endcase
        end
    end

    always @(negedge clock) begin
        if (model_on) begin
            check_output("in_ready", 32'(in_ready), 32'(exp_in_ready));
            check_output("out_valid", 32'(out_valid), 32'(exp_out_valid));
            check_output("out_last", 32'(out_last), 32'(exp_out_last));
            check_output("busy", 32'(busy), 32'(exp_busy));
            check_output("overflow", 32'(overflow), 32'(exp_overflow));
            if (exp_out_valid || exp_rst_vals) check_output("out_data", 32'(out_data), 32'(exp_out_data));
            if (exp_busy || exp_rst_vals) check_output("pkt_len", 32'(pkt_len), 32'(exp_pkt_len));
        end
    end

    always @(posedge clock) begin
        if (!reset && out_valid && out_ready) got.push_back(out_data);
    end

    always @(negedge clock) begin
        if (rand_ready_en) out_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic apply_stimulus(input logic [3:0] d, input logic last, input bit gaps);
        int g = 0;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                @(negedge clock);
                in_valid = 1'b0; in_last = 1'($urandom); in_data = 4'($urandom);
            end
        end
        @(negedge clock);
        in_valid = 1'b1; in_data = d; in_last = last;
        while (!in_ready && g < 200) begin
            @(negedge clock);
            g++;
        end
        check_output("send_ready", 32'(in_ready), 1);
        @(posedge clock);
        #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic wait_out_valid(output int n);
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clock);
            #1;
            n++;
        end
    endtask

    task automatic wait_words(input int n);
        int g = 0;
        while (got.size() < n && g < 200) begin
            @(negedge clock);
            g++;
        end
        check_output("words_seen", 32'(got.size()), 32'(n));
    endtask

    task automatic wait_in_ready();
        int g = 0;
        @(posedge clock);
        #1;
        while (!in_ready && g < 200) begin
            @(posedge clock);
            #1;
            g++;
        end
        check_output("in_ready_wait", 32'(in_ready), 1);
    endtask

    task automatic check_got(input string name, input int n, input logic [15:0] words);
        logic [3:0] e;
        check_output({name, "_count"}, 32'(got.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            e = words[(n - 1 - i) * 4 +: 4];
            if (i < got.size()) check_output(name, 32'(got[i]), 32'(e));
        end
    endtask

    initial begin
        int lat;
        int len;
        logic [3:0] held;
        reset = 1'b1; in_valid = 1'b0; in_data = 4'h0; in_last = 1'b0; out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_data = 4'h0; b_in_last = 1'b0; b_out_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check_output("rst_in_ready", 32'(in_ready), 0);
        check_output("rst_out_valid", 32'(out_valid), 0);
        check_output("rst_pkt_len", 32'(pkt_len), 0);
        @(negedge clock) reset = 1'b0;
        @(posedge clock);
        #1;
        check_output("in_ready_after_reset", 32'(in_ready), 1);

        // Four-word packet, full depth
        got.delete();
        apply_stimulus(4'h1, 1'b0, 1'b0); apply_stimulus(4'h2, 1'b0, 1'b0);
        apply_stimulus(4'h3, 1'b0, 1'b0); apply_stimulus(4'h4, 1'b1, 1'b0);
        wait_out_valid(lat);
        check_output("latency_pkt1", 32'(lat), 4);
        check_output("pkt1_len", 32'(pkt_len), 4);
        check_output("pkt1_overflow", 32'(overflow), 0);
        check_output("pkt1_first", 32'(out_data), 32'h2);
        wait_words(4);
        check_got("pkt1", 4, 16'h2C48);
        check_output("pkt1_last_flag_cleared", 32'(out_last), 0);
        wait_in_ready();

        // Single-word packet
        got.delete();
        apply_stimulus(4'h6, 1'b1, 1'b0);
        wait_out_valid(lat);
        check_output("latency_single", 32'(lat), 4);
        check_output("single_len", 32'(pkt_len), 1);
        check_output("single_last", 32'(out_last), 1);
        wait_words(1);
        check_got("single", 1, 16'h0006);
        wait_in_ready();

        // Six words into a four-deep buffer
        got.delete();
        for (int i = 1; i <= 6; i++) apply_stimulus(4'(i), (i == 6), 1'b0);
        wait_out_valid(lat);
        check_output("ovf_len", 32'(pkt_len), 4);
        check_output("ovf_flag", 32'(overflow), 1);
        wait_words(4);
        check_got("ovf", 4, 16'h2C48);
        wait_in_ready();
        check_output("ovf_sticky", 32'(overflow), 1);

        // Next packet clears overflow on its first word, then stalls in DRAIN
        got.delete();
        apply_stimulus(4'h1, 1'b0, 1'b0);
        check_output("ovf_cleared", 32'(overflow), 0);
        apply_stimulus(4'h2, 1'b0, 1'b0); apply_stimulus(4'h3, 1'b0, 1'b0);
        apply_stimulus(4'h4, 1'b1, 1'b0);
        out_ready = 1'b0;
        wait_out_valid(lat);
        held = out_data;
        check_output("stall_head", 32'(held), 32'h2);
        repeat (5) begin
            @(posedge clock);
            #1;
            check_output("stall_data", 32'(out_data), 32'h2);
            check_output("stall_in_ready", 32'(in_ready), 0);
            check_output("stall_valid", 32'(out_valid), 1);
        end
        out_ready = 1'b1;
        wait_words(4);
        check_got("stall", 4, 16'h2C48);
        wait_in_ready();

        // Reset in the middle of DRAIN
        got.delete();
        apply_stimulus(4'h1, 1'b0, 1'b0); apply_stimulus(4'h2, 1'b0, 1'b0);
        apply_stimulus(4'h3, 1'b0, 1'b0); apply_stimulus(4'h4, 1'b1, 1'b0);
        wait_words(2);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check_output("midrst_out_valid", 32'(out_valid), 0);
        check_output("midrst_in_ready", 32'(in_ready), 0);
        check_output("midrst_busy", 32'(busy), 0);
        @(negedge clock) reset = 1'b0;
        @(posedge clock);
        #1;
        check_output("midrst_in_ready_after", 32'(in_ready), 1);
        got.delete();
        apply_stimulus(4'h3, 1'b0, 1'b0); apply_stimulus(4'h5, 1'b1, 1'b0);
        wait_words(2);
        check_got("after_rst", 2, 16'h00AC);
        wait_in_ready();

        // Randomized traffic with gaps, stray in_last and random backpressure
        rand_ready_en = 1'b1;
        repeat (12) begin
            len = $urandom_range(1, 6);
            for (int i = 0; i < len; i++) apply_stimulus(4'($urandom), (i == len - 1), 1'b1);
        end
        @(posedge clock);
        #1;
        rand_ready_en = 1'b0;
        out_ready = 1'b1;
        wait_in_ready();

        // BIT_REV=0, DELAY=0 build
        @(negedge clock);
        check_output("b_in_ready", 32'(b_in_ready), 1);
        b_in_valid = 1'b1; b_in_data = 4'hA; b_in_last = 1'b0;
        @(negedge clock);
        b_in_data = 4'h5; b_in_last = 1'b1;
        @(posedge clock);
        #1;
        b_in_valid = 1'b0; b_in_last = 1'b0;
        check_output("b_hold_valid", 32'(b_out_valid), 0);
        check_output("b_hold_in_ready", 32'(b_in_ready), 0);
        @(posedge clock);
        #1;
        check_output("b_first_valid", 32'(b_out_valid), 1);
        check_output("b_first_data", 32'(b_out_data), 32'h5);
        check_output("b_first_last", 32'(b_out_last), 0);
        check_output("b_pkt_len", 32'(b_pkt_len), 2);
        @(posedge clock);
        #1;
        check_output("b_second_data", 32'(b_out_data), 32'hA);
        check_output("b_second_last", 32'(b_out_last), 1);
        @(posedge clock);
        #1;
        check_output("b_done_valid", 32'(b_out_valid), 0);
        check_output("b_done_in_ready", 32'(b_in_ready), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        errors++;
        $display("[TB] FAIL watchdog actual=running expected=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
